// File: rtl/pc_next_gen.sv
// Fetch-stage PC generator: holds the PC register and picks the next fetch PC.
// Latency: one cycle; every output is registered, so a request on edge N is visible after edge N.
// Backpressure: stall holds the PC and parks the winning jr/jt/bt redirect; traps bypass stall.
//
// Ports:
//   clk, rst_n                    rising-edge clock, asynchronous active-low reset
//   stall                         fetch cannot accept a new PC this cycle
//   xcpt_req, illop_req, xcpt_pc  trap requests and the PC of the trapping instruction
//   jr_req/jr_tgt, jt_req/jt_tgt, bt_req/bt_tgt   control-flow redirects (priority jr > jt > bt)
//   pc, pc_valid                  current fetch PC and its live flag
//   flush                         one-cycle pulse after every applied redirect
//   epc                           saved exception PC
//   pend                          a deferred redirect is being held
//   misalign                      one-cycle pulse on a misaligned-target trap
//
// Optional feature: define PC_ALIGN_CHECK_EN to trap applied jr/jt/bt targets whose low
// two bits are non-zero to ILLOP_VECTOR. Without it, targets load unchanged and
// misalign is constant 0.

module pc_next_gen #(
    parameter int unsigned    W            = 32,
    parameter int unsigned    INC          = 4,
    parameter logic [W-1:0]   RESET_VECTOR = 32'h0000_3000,
    parameter logic [W-1:0]   EXC_VECTOR   = 32'h0000_4180,
    parameter logic [W-1:0]   ILLOP_VECTOR = 32'h0000_4200
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic         xcpt_req,
    input  logic         illop_req,
    input  logic [W-1:0] xcpt_pc,
    input  logic         jr_req,
    input  logic [W-1:0] jr_tgt,
    input  logic         jt_req,
    input  logic [W-1:0] jt_tgt,
    input  logic         bt_req,
    input  logic [W-1:0] bt_tgt,
    output logic [W-1:0] pc,
    output logic         pc_valid,
    output logic         flush,
    output logic [W-1:0] epc,
    output logic         pend,
    output logic         misalign
);

    // Redirect priority encoding used for the pending entry comparison.
    localparam logic [1:0] PRIO_JR = 2'd2;
    localparam logic [1:0] PRIO_JT = 2'd1;
    localparam logic [1:0] PRIO_BT = 2'd0;

    localparam logic [W-1:0] INC_W = W'(INC);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [W-1:0] pc_q,        pc_d;
    logic         pc_valid_q,  pc_valid_d;
    logic         flush_q,     flush_d;
    logic [W-1:0] epc_q,       epc_d;
    logic         pend_q,      pend_d;
    logic [W-1:0] pend_tgt_q,  pend_tgt_d;
    logic [1:0]   pend_prio_q, pend_prio_d;
`ifdef PC_ALIGN_CHECK_EN
    logic         misalign_q,  misalign_d;
`endif

    // ------------------------------------------------------------------
    // Control-flow arbitration: best current request vs. pending entry
    // ------------------------------------------------------------------
    logic         cur_vld;
    logic [1:0]   cur_prio;
    logic [W-1:0] cur_tgt;
    logic         take_cur;
    logic         win_vld;
    logic [1:0]   win_prio;
    logic [W-1:0] win_tgt;

    always_comb begin
        cur_vld  = jr_req | jt_req | bt_req;
        cur_prio = PRIO_BT;
        cur_tgt  = bt_tgt;
        if (jr_req) begin
            cur_prio = PRIO_JR;
            cur_tgt  = jr_tgt;
        end else if (jt_req) begin
            cur_prio = PRIO_JT;
            cur_tgt  = jt_tgt;
        end

        // A fresh request of equal priority replaces the parked one: the
        // newer target reflects the most recent decode of that redirect kind.
        take_cur = cur_vld && (!pend_q || (cur_prio >= pend_prio_q));
        win_vld  = take_cur || pend_q;
        win_prio = take_cur ? cur_prio : pend_prio_q;
        win_tgt  = take_cur ? cur_tgt  : pend_tgt_q;
    end

    // ------------------------------------------------------------------
    // Next-state selection
    // ------------------------------------------------------------------
    always_comb begin
        pc_d        = pc_q;
        pc_valid_d  = pc_valid_q;
        flush_d     = 1'b0;
        epc_d       = epc_q;
        pend_d      = pend_q;
        pend_tgt_d  = pend_tgt_q;
        pend_prio_d = pend_prio_q;
`ifdef PC_ALIGN_CHECK_EN
        misalign_d  = 1'b0;
`endif

        if (!pc_valid_q) begin
            // First edge out of reset only arms fetch; the reset vector is
            // presented once as a valid PC before anything may move it.
            pc_valid_d = 1'b1;
        end else if (xcpt_req || illop_req) begin
            // Traps are taken regardless of stall and discard any parked redirect.
            pc_d        = xcpt_req ? EXC_VECTOR : ILLOP_VECTOR;
            epc_d       = xcpt_pc;
            flush_d     = 1'b1;
            pend_d      = 1'b0;
            pend_tgt_d  = '0;
            pend_prio_d = PRIO_BT;
        end else if (win_vld) begin
            if (stall) begin
                // Park the winner until fetch can accept it.
                pend_d      = 1'b1;
                pend_tgt_d  = win_tgt;
                pend_prio_d = win_prio;
            end else begin
                pend_d      = 1'b0;
                pend_tgt_d  = '0;
                pend_prio_d = PRIO_BT;
                flush_d     = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
                // Alignment is judged only when the target is actually applied.
                if (win_tgt[1:0] != 2'b00) begin
                    pc_d       = ILLOP_VECTOR;
                    epc_d      = win_tgt;
                    misalign_d = 1'b1;
                end else begin
                    pc_d = win_tgt;
                end
`else
                pc_d = win_tgt;
`endif
            end
        end else if (!stall) begin
            pc_d = pc_q + INC_W;   // wraps modulo 2^W
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_VECTOR;
            pc_valid_q  <= 1'b0;
            flush_q     <= 1'b0;
            epc_q       <= '0;
            pend_q      <= 1'b0;
            pend_tgt_q  <= '0;
            pend_prio_q <= PRIO_BT;
`ifdef PC_ALIGN_CHECK_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            pc_q        <= pc_d;
            pc_valid_q  <= pc_valid_d;
            flush_q     <= flush_d;
            epc_q       <= epc_d;
            pend_q      <= pend_d;
            pend_tgt_q  <= pend_tgt_d;
            pend_prio_q <= pend_prio_d;
`ifdef PC_ALIGN_CHECK_EN
            misalign_q  <= misalign_d;
`endif
        end
    end

    assign pc       = pc_q;
    assign pc_valid = pc_valid_q;
    assign flush    = flush_q;
    assign epc      = epc_q;
    assign pend     = pend_q;
`ifdef PC_ALIGN_CHECK_EN
    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pc_next_gen.sv
// Directed bench for pc_next_gen: each vector drives one cycle of inputs and queues the
// hand-computed post-edge outputs; a monitor pops and compares one entry per clock edge.
// Ends with a single summary line.

module tb_pc_next_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        xcpt_req = 1'b0;
    logic        illop_req = 1'b0;
    logic [31:0] xcpt_pc = '0;
    logic        jr_req = 1'b0;
    logic [31:0] jr_tgt = '0;
    logic        jt_req = 1'b0;
    logic [31:0] jt_tgt = '0;
    logic        bt_req = 1'b0;
    logic [31:0] bt_tgt = '0;
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush;
    logic [31:0] epc;
    logic        pend;
    logic        misalign;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        vld;
        logic        flush;
        logic [31:0] epc;
        logic        pend;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    pc_next_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .xcpt_req  (xcpt_req),
        .illop_req (illop_req),
        .xcpt_pc   (xcpt_pc),
        .jr_req    (jr_req),
        .jr_tgt    (jr_tgt),
        .jt_req    (jt_req),
        .jt_tgt    (jt_tgt),
        .bt_req    (bt_req),
        .bt_tgt    (bt_tgt),
        .pc        (pc),
        .pc_valid  (pc_valid),
        .flush     (flush),
        .epc       (epc),
        .pend      (pend),
        .misalign  (misalign)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string vec, input string fld, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", vec, fld, act, req);
        end
    endtask

    // Monitor: every output is registered, so sample just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            cmp(e.name, "pc",       pc,              e.pc);
            cmp(e.name, "pc_valid", {31'd0, pc_valid}, {31'd0, e.vld});
            cmp(e.name, "flush",    {31'd0, flush},    {31'd0, e.flush});
            cmp(e.name, "epc",      epc,             e.epc);
            cmp(e.name, "pend",     {31'd0, pend},     {31'd0, e.pend});
            cmp(e.name, "misalign", {31'd0, misalign}, {31'd0, e.mis});
        end
    end

    // Inputs were set by the caller at a falling edge; queue the expected result of the
    // coming rising edge, let it pass, then drop the one-shot request strobes.
    task automatic go(input string name, input logic [31:0] e_pc, input logic e_vld,
                      input logic e_flush, input logic [31:0] e_epc, input logic e_pend,
                      input logic e_mis);
        exp_t e;
        e.name = name; e.pc = e_pc; e.vld = e_vld; e.flush = e_flush;
        e.epc = e_epc; e.pend = e_pend; e.mis = e_mis;
        exp_q.push_back(e);
        @(negedge clk);
        xcpt_req  = 1'b0;
        illop_req = 1'b0;
        jr_req    = 1'b0;
        jt_req    = 1'b0;
        bt_req    = 1'b0;
    endtask

    logic [31:0] mis_pc;
    logic [31:0] mis_epc;
    logic [31:0] mis_next;
    logic        mis_flag;

    initial begin
`ifdef PC_ALIGN_CHECK_EN
        mis_pc = 32'h0000_4200; mis_epc = 32'h0000_5002; mis_next = 32'h0000_4204; mis_flag = 1'b1;
`else
        mis_pc = 32'h0000_5002; mis_epc = 32'h0000_3060; mis_next = 32'h0000_5006; mis_flag = 1'b0;
`endif
        @(negedge clk);

        // Reset and release; a request on the arming edge is ignored.
        go("rst",        32'h3000, 0, 0, 32'h0, 0, 0);
        rst_n = 1'b1; jr_req = 1'b1; jr_tgt = 32'h5000;
        go("arm",        32'h3000, 1, 0, 32'h0, 0, 0);
        go("seq1",       32'h3004, 1, 0, 32'h0, 0, 0);
        go("seq2",       32'h3008, 1, 0, 32'h0, 0, 0);
        go("seq3",       32'h300C, 1, 0, 32'h0, 0, 0);
        go("seq4",       32'h3010, 1, 0, 32'h0, 0, 0);

        // Taken branch, unstalled.
        bt_req = 1'b1; bt_tgt = 32'h3100;
        go("bt",         32'h3100, 1, 1, 32'h0, 0, 0);
        go("bt_next",    32'h3104, 1, 0, 32'h0, 0, 0);

        // bt parked, then outranked by jr while stalled.
        stall = 1'b1; bt_req = 1'b1; bt_tgt = 32'h3100;
        go("st_bt",      32'h3104, 1, 0, 32'h0, 1, 0);
        jr_req = 1'b1; jr_tgt = 32'h5000;
        go("st_jr",      32'h3104, 1, 0, 32'h0, 1, 0);
        go("st_hold",    32'h3104, 1, 0, 32'h0, 1, 0);
        stall = 1'b0;
        go("st_rel",     32'h5000, 1, 1, 32'h0, 0, 0);
        go("st_rel_nx",  32'h5004, 1, 0, 32'h0, 0, 0);

        // Lower-priority request while a jr is parked is ignored.
        stall = 1'b1; jr_req = 1'b1; jr_tgt = 32'h6000;
        go("lo_jr",      32'h5004, 1, 0, 32'h0, 1, 0);
        bt_req = 1'b1; bt_tgt = 32'h7000;
        go("lo_bt",      32'h5004, 1, 0, 32'h0, 1, 0);
        stall = 1'b0;
        go("lo_rel",     32'h6000, 1, 1, 32'h0, 0, 0);

        // Back-to-back redirects keep flush high.
        jt_req = 1'b1; jt_tgt = 32'h9000;
        go("b2b_jt",     32'h9000, 1, 1, 32'h0, 0, 0);
        bt_req = 1'b1; bt_tgt = 32'h9100;
        go("b2b_bt",     32'h9100, 1, 1, 32'h0, 0, 0);
        go("b2b_seq",    32'h9104, 1, 0, 32'h0, 0, 0);
        stall = 1'b1;
        go("stall_hold", 32'h9104, 1, 0, 32'h0, 0, 0);

        // Equal priority replaces the parked entry.
        jt_req = 1'b1; jt_tgt = 32'h8000;
        go("eq_jt1",     32'h9104, 1, 0, 32'h0, 1, 0);
        jt_req = 1'b1; jt_tgt = 32'h8800;
        go("eq_jt2",     32'h9104, 1, 0, 32'h0, 1, 0);
        stall = 1'b0;
        go("eq_rel",     32'h8800, 1, 1, 32'h0, 0, 0);

        // Parked jr beats a current bt on release.
        stall = 1'b1; jr_req = 1'b1; jr_tgt = 32'hA000;
        go("pj_park",    32'h8800, 1, 0, 32'h0, 1, 0);
        stall = 1'b0; bt_req = 1'b1; bt_tgt = 32'hB000;
        go("pj_rel",     32'hA000, 1, 1, 32'h0, 0, 0);

        // Trap while stalled with a pending redirect.
        stall = 1'b1; bt_req = 1'b1; bt_tgt = 32'h3100;
        go("tr_park",    32'hA000, 1, 0, 32'h0, 1, 0);
        xcpt_req = 1'b1; xcpt_pc = 32'h3020;
        go("tr_xcpt",    32'h4180, 1, 1, 32'h3020, 0, 0);
        go("tr_hold",    32'h4180, 1, 0, 32'h3020, 0, 0);
        stall = 1'b0;
        go("tr_seq",     32'h4184, 1, 0, 32'h3020, 0, 0);

        // illop beats jr in the same cycle.
        illop_req = 1'b1; jr_req = 1'b1; jr_tgt = 32'h5000; xcpt_pc = 32'h3040;
        go("illop",      32'h4200, 1, 1, 32'h3040, 0, 0);
        go("illop_seq",  32'h4204, 1, 0, 32'h3040, 0, 0);

        // xcpt beats illop.
        xcpt_req = 1'b1; illop_req = 1'b1; xcpt_pc = 32'h3060;
        go("xc_il",      32'h4180, 1, 1, 32'h3060, 0, 0);
        go("xc_il_seq",  32'h4184, 1, 0, 32'h3060, 0, 0);

        // Wrap at the top of the address space.
        jt_req = 1'b1; jt_tgt = 32'hFFFF_FFFC;
        go("wrap_ld",    32'hFFFF_FFFC, 1, 1, 32'h3060, 0, 0);
        go("wrap",       32'h0000_0000, 1, 0, 32'h3060, 0, 0);
        go("wrap_nx",    32'h0000_0004, 1, 0, 32'h3060, 0, 0);

        // Misaligned jr target.
        jr_req = 1'b1; jr_tgt = 32'h5002;
        go("mis",        mis_pc,   1, 1, mis_epc, 0, mis_flag);
        go("mis_nx",     mis_next, 1, 0, mis_epc, 0, 0);

        // Reset mid-operation discards the parked redirect.
        stall = 1'b1; jr_req = 1'b1; jr_tgt = 32'h7000;
        go("mr_park",    mis_next, 1, 0, mis_epc, 1, 0);
        rst_n = 1'b0;
        go("mr_rst",     32'h3000, 0, 0, 32'h0, 0, 0);
        rst_n = 1'b1; stall = 1'b0;
        go("mr_arm",     32'h3000, 1, 0, 32'h0, 0, 0);
        go("mr_seq",     32'h3004, 1, 0, 32'h0, 0, 0);

        // Drain: every queued expectation must have been consumed.
        repeat (4) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
